// File: rtl/bram_arbiter_if.sv
// Request/response bundle between two client ports and the BRAM arbiter.
interface bram_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  a_req_valid;
  logic                  a_req_ready;
  logic                  a_req_we;
  logic [ADDR_WIDTH-1:0] a_req_addr;
  logic [DATA_WIDTH-1:0] a_req_wdata;
  logic                  a_rsp_valid;

  logic                  b_req_valid;
  logic                  b_req_ready;
  logic                  b_req_we;
  logic [ADDR_WIDTH-1:0] b_req_addr;
  logic [DATA_WIDTH-1:0] b_req_wdata;
  logic                  b_rsp_valid;

  logic [DATA_WIDTH-1:0] rsp_rdata;

  // Client side: drives requests, sees ready and responses.
  modport master (
    output a_req_valid, a_req_we, a_req_addr, a_req_wdata,
    output b_req_valid, b_req_we, b_req_addr, b_req_wdata,
    input  a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, rsp_rdata
  );

  // Arbiter side.
  modport slave (
    input  a_req_valid, a_req_we, a_req_addr, a_req_wdata,
    input  b_req_valid, b_req_we, b_req_addr, b_req_wdata,
    output a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, read-first BRAM
// with 1-cycle read latency. One request per cycle, response two cycles later.
module bram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_arbiter_if.slave         bus,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  a_grant_cnt,
  output logic [CNT_WIDTH-1:0]  b_grant_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic ptr_b;    // 1: port B has priority when both request
  logic hs_a;
  logic hs_b;
  logic iss_vld;  // issue tag, aligned with ram_we/ram_addr
  logic iss_b;
  logic stg_vld;  // read tag, aligned with ram_dout
  logic stg_b;

  // Grant selection; ready implies valid, so ready is also the handshake.
  always_comb begin
    hs_a = 1'b0;
    hs_b = 1'b0;
    if (rst_n) begin
      hs_a = bus.a_req_valid && (!bus.b_req_valid || !ptr_b);
      hs_b = bus.b_req_valid && (!bus.a_req_valid ||  ptr_b);
    end
    bus.a_req_ready = hs_a;
    bus.b_req_ready = hs_b;
  end

  // Issue stage, pointer and response pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_b           <= 1'b0;
      ram_we          <= 1'b0;
      ram_addr        <= '0;
      ram_din         <= '0;
      iss_vld         <= 1'b0;
      iss_b           <= 1'b0;
      stg_vld         <= 1'b0;
      stg_b           <= 1'b0;
      bus.a_rsp_valid <= 1'b0;
      bus.b_rsp_valid <= 1'b0;
      bus.rsp_rdata   <= '0;
    end else begin
      ram_we <= 1'b0;
      if (hs_b) begin
        ram_we   <= bus.b_req_we;
        ram_addr <= bus.b_req_addr;
        ram_din  <= bus.b_req_wdata;
        ptr_b    <= 1'b0;
      end else if (hs_a) begin
        ram_we   <= bus.a_req_we;
        ram_addr <= bus.a_req_addr;
        ram_din  <= bus.a_req_wdata;
        ptr_b    <= 1'b1;
      end
      iss_vld         <= hs_a || hs_b;
      iss_b           <= hs_b;
      stg_vld         <= iss_vld;
      stg_b           <= iss_b;
      bus.a_rsp_valid <= stg_vld && !stg_b;
      bus.b_rsp_valid <= stg_vld &&  stg_b;
      if (stg_vld) begin
        bus.rsp_rdata <= ram_dout;
      end
    end
  end

  // Saturating per-port grant counters; clear beats a coincident grant.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
    end else begin
      if (hs_a && (a_grant_cnt != CNT_MAX)) begin
        a_grant_cnt <= a_grant_cnt + CNT_WIDTH'(1);
      end
      if (hs_b && (b_grant_cnt != CNT_MAX)) begin
        b_grant_cnt <= b_grant_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: BRAM model, reference memory, ready model and
// response scoreboard. Counters are narrowed to 4 bits to reach saturation.
module tb_bram_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  typedef struct {
    logic          rst_n;
    logic          a_valid;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          b_valid;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          clr;
  } stim_t;

  typedef struct {
    stim_t s;
    logic  ea;
    logic  eb;
  } vec_t;

  typedef struct {
    logic          port_b;
    logic [DW-1:0] rdata;
    int            due;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          cnt_clr;
  logic [CW-1:0] a_grant_cnt;
  logic [CW-1:0] b_grant_cnt;

  bram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout),
    .cnt_clr     (cnt_clr),
    .a_grant_cnt (a_grant_cnt),
    .b_grant_cnt (b_grant_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 37 + 5);
  endfunction

  // Read-first single-port RAM, 1-cycle registered read.
  logic [DW-1:0] mem [256];
  logic          init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      init_done <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  // Reference state (values expected after the next edge).
  logic [DW-1:0] ref_mem [256];
  sb_t           sbq[$];
  logic          m_ptr_b = 1'b0;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_din   = '0;
  logic [CW-1:0] m_cnt_a = '0;
  logic [CW-1:0] m_cnt_b = '0;
  logic [DW-1:0] last_a_rdata = '0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic stim_t mk(input logic rn, input logic av, input logic awe,
                               input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                               input logic bv, input logic bwe,
                               input logic [AW-1:0] bad, input logic [DW-1:0] bwd,
                               input logic clr);
    stim_t s;
    s.rst_n = rn;  s.a_valid = av; s.a_we = awe; s.a_addr = aad; s.a_wdata = awd;
    s.b_valid = bv; s.b_we = bwe; s.b_addr = bad; s.b_wdata = bwd; s.clr = clr;
    return s;
  endfunction

  function automatic vec_t mkv(input stim_t s, input logic ea, input logic eb);
    vec_t v;
    v.s = s; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  // Compare registered outputs against the reference after the last edge.
  task automatic monitor();
    sb_t e;
    chk("rsp_exclusive", 32'(bus.a_rsp_valid & bus.b_rsp_valid), 32'(0));
    chk("ram_we", 32'(ram_we), 32'(m_we));
    chk("ram_addr", 32'(ram_addr), 32'(m_addr));
    chk("ram_din", 32'(ram_din), 32'(m_din));
    chk("a_grant_cnt", 32'(a_grant_cnt), 32'(m_cnt_a));
    chk("b_grant_cnt", 32'(b_grant_cnt), 32'(m_cnt_b));
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("a_rsp_valid", 32'(bus.a_rsp_valid), 32'(!e.port_b));
      chk("b_rsp_valid", 32'(bus.b_rsp_valid), 32'(e.port_b));
      chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
      if (!e.port_b) last_a_rdata = bus.rsp_rdata;
    end else begin
      chk("a_rsp_idle", 32'(bus.a_rsp_valid), 32'(0));
      chk("b_rsp_idle", 32'(bus.b_rsp_valid), 32'(0));
    end
  endtask

  // One cycle: check outputs, drive stimulus, check ready, update model.
  task automatic step(input stim_t s, output logic ra, output logic rb);
    logic          ea, eb, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    sb_t           e;
    @(negedge clk);
    monitor();
    rst_n           = s.rst_n;
    cnt_clr         = s.clr;
    bus.a_req_valid = s.a_valid;
    bus.a_req_we    = s.a_we;
    bus.a_req_addr  = s.a_addr;
    bus.a_req_wdata = s.a_wdata;
    bus.b_req_valid = s.b_valid;
    bus.b_req_we    = s.b_we;
    bus.b_req_addr  = s.b_addr;
    bus.b_req_wdata = s.b_wdata;
    #1;
    ra = bus.a_req_ready;
    rb = bus.b_req_ready;
    ea = s.rst_n && s.a_valid && (!s.b_valid || !m_ptr_b);
    eb = s.rst_n && s.b_valid && (!s.a_valid ||  m_ptr_b);
    chk("a_req_ready", 32'(ra), 32'(ea));
    chk("b_req_ready", 32'(rb), 32'(eb));
    if (!s.rst_n) begin
      sbq.delete();
      m_ptr_b = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0;
      m_cnt_a = '0;   m_cnt_b = '0;
    end else begin
      m_we = 1'b0;
      if (ea || eb) begin
        addr = ea ? s.a_addr  : s.b_addr;
        we   = ea ? s.a_we    : s.b_we;
        wd   = ea ? s.a_wdata : s.b_wdata;
        m_we = we; m_addr = addr; m_din = wd;
        e.port_b = eb;
        e.rdata  = ref_mem[addr];
        e.due    = cyc + 3;
        sbq.push_back(e);
        if (we) ref_mem[addr] = wd;
        m_ptr_b = ea;
      end
      if (s.clr) begin
        m_cnt_a = '0;
        m_cnt_b = '0;
      end else begin
        if (ea && m_cnt_a != CMAX) m_cnt_a = m_cnt_a + CW'(1);
        if (eb && m_cnt_b != CMAX) m_cnt_b = m_cnt_b + CW'(1);
      end
    end
  endtask

  vec_t  vecs[$];
  stim_t idle;
  logic  ra, rb;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    idle = mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);

    // Arbitration vectors starting from the reset pointer (A).
    vecs.push_back(mkv(mk(0, 1, 1, 8'h01, 8'h11, 1, 1, 8'h02, 8'h22, 0), 0, 0));
    vecs.push_back(mkv(mk(1, 1, 1, 8'h30, 8'hA0, 1, 0, 8'h31, 8'h00, 0), 1, 0));
    vecs.push_back(mkv(mk(1, 1, 1, 8'h30, 8'hA0, 1, 0, 8'h30, 8'h00, 0), 0, 1));
    vecs.push_back(mkv(mk(1, 1, 0, 8'h31, 8'h00, 1, 1, 8'h31, 8'hB1, 0), 1, 0));
    vecs.push_back(mkv(mk(1, 1, 0, 8'h31, 8'h00, 1, 1, 8'h31, 8'hB1, 0), 0, 1));
    vecs.push_back(mkv(mk(1, 1, 0, 8'h31, 8'h00, 1, 0, 8'h32, 8'h00, 0), 1, 0));
    vecs.push_back(mkv(mk(1, 1, 1, 8'h32, 8'hA2, 1, 0, 8'h31, 8'h00, 0), 0, 1));
    vecs.push_back(mkv(mk(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'hB4, 0), 0, 1));
    vecs.push_back(mkv(mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 0), 0, 1));
    vecs.push_back(mkv(mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h41, 8'h00, 0), 0, 1));
    vecs.push_back(mkv(mk(1, 1, 0, 8'h40, 8'h00, 1, 1, 8'h41, 8'hB5, 0), 1, 0));
    vecs.push_back(mkv(mk(1, 1, 1, 8'h42, 8'hA6, 0, 0, 8'h00, 8'h00, 0), 1, 0));
    vecs.push_back(mkv(mk(1, 1, 0, 8'h42, 8'h00, 1, 0, 8'h41, 8'h00, 0), 0, 1));
    vecs.push_back(mkv(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0), 0, 0));
    vecs.push_back(mkv(mk(1, 1, 0, 8'h30, 8'h00, 1, 0, 8'h32, 8'h00, 0), 1, 0));

    // Power-on reset before the monitor starts comparing.
    rst_n = 1'b0; cnt_clr = 1'b0;
    bus.a_req_valid = 1'b0; bus.a_req_we = 1'b0; bus.a_req_addr = '0; bus.a_req_wdata = '0;
    bus.b_req_valid = 1'b0; bus.b_req_we = 1'b0; bus.b_req_addr = '0; bus.b_req_wdata = '0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].s, ra, rb);
      chk($sformatf("vec%0d_a_ready", i), 32'(ra), 32'(vecs[i].ea));
      chk($sformatf("vec%0d_b_ready", i), 32'(rb), 32'(vecs[i].eb));
      if (i == 6) begin
        @(posedge clk); #1;
        chk("alt6_a_cnt", 32'(a_grant_cnt), 32'(3));
        chk("alt6_b_cnt", 32'(b_grant_cnt), 32'(3));
      end
    end
    repeat (4) step(idle, ra, rb);

    // Write then back-to-back read of the same address from port A.
    step(mk(1, 1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 0), ra, rb);
    step(mk(1, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0), ra, rb);
    repeat (4) step(idle, ra, rb);
    chk("wr_then_rd_data", 32'(last_a_rdata), 32'(8'h5A));

    // Read in flight when reset hits: its response must never appear.
    step(mk(1, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0), ra, rb);
    step(mk(0, 1, 0, 8'h20, 8'h00, 1, 0, 8'h21, 8'h00, 0), ra, rb);
    chk("reset_a_ready", 32'(ra), 32'(0));
    chk("reset_b_ready", 32'(rb), 32'(0));
    repeat (4) step(idle, ra, rb);
    step(mk(1, 1, 0, 8'h22, 8'h00, 1, 0, 8'h23, 8'h00, 0), ra, rb);
    chk("ptr_after_reset", 32'({ra, rb}), 32'(2'b10));

    // Counter saturation, then clear coinciding with a grant.
    repeat (16) step(mk(1, 1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00, 0), ra, rb);
    @(posedge clk); #1;
    chk("a_cnt_saturated", 32'(a_grant_cnt), 32'(15));
    step(mk(1, 1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00, 1), ra, rb);
    @(posedge clk); #1;
    chk("cnt_clr_wins", 32'(a_grant_cnt), 32'(0));

    // Random mixed traffic on a small address window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      stim_t s;
      s = mk(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 15)), DW'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 15)), DW'($urandom),
             1'($urandom_range(0, 19) == 0));
      step(s, ra, rb);
    end
    repeat (5) step(idle, ra, rb);
    chk("scoreboard_drained", 32'(sbq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, RAM word width.
REQ-002 Parameter ADDR_WIDTH, default 8, RAM address width.
REQ-003 Parameter CNT_WIDTH, default 16, grant-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 a_req_valid, b_req_valid  input  1  port A/B request present.
REQ-007 a_req_ready, b_req_ready  output  1  port A/B request accepted this cycle.
REQ-008 a_req_we, b_req_we  input  1  1 = write, 0 = read.
REQ-009 a_req_addr, b_req_addr  input  ADDR_WIDTH  request address.
REQ-010 a_req_wdata, b_req_wdata  input  DATA_WIDTH  write data.
REQ-011 a_rsp_valid, b_rsp_valid  output  1  one-cycle response strobe to the port.
REQ-012 rsp_rdata  output  DATA_WIDTH  response data shared by both ports; meaningful only while a rsp_valid is high.
REQ-013 ram_we  output  1  write enable to the single-port RAM.
REQ-014 ram_addr  output  ADDR_WIDTH  RAM address.
REQ-015 ram_din  output  DATA_WIDTH  RAM write data.
REQ-016 ram_dout  input  DATA_WIDTH  RAM registered read data, read-first, 1-cycle latency.
REQ-017 cnt_clr  input  1  synchronous clear of the grant counters.
REQ-018 a_grant_cnt, b_grant_cnt  output  CNT_WIDTH  accepted-request counts per port.

Function
REQ-019 The arbiter SHALL accept at most one request per cycle; a handshake occurs when x_req_valid and x_req_ready are both high at a rising edge.
REQ-020 x_req_ready SHALL be combinational from both valid inputs and the priority pointer; a port is never ready while its valid is low.
REQ-021 Only one valid: that port SHALL be granted, irrespective of the pointer.
REQ-022 Both valid: the port named by the priority pointer SHALL be granted.
REQ-023 After every handshake, the pointer SHALL move to the port not granted; with no handshake it SHALL hold.
REQ-024 Issue stage: on a handshake, ram_we, ram_addr and ram_din SHALL be registered from the granted port; ram_we is the granted port's req_we.
REQ-025 With no handshake, ram_we SHALL register 0; ram_addr and ram_din SHALL hold their previous values.
REQ-026 ram_we SHALL be high for exactly one cycle per accepted write.
REQ-027 Two pipeline tags (valid, port) SHALL track each request: the issue tag and one later stage aligned with ram_dout.
REQ-028 Every accepted request, read or write, SHALL produce exactly one x_rsp_valid pulse on the originating port.
REQ-029 The response SHALL come two cycles after the handshake edge: a request accepted at edge N pulses rsp_valid during the cycle after edge N+2.
REQ-030 rsp_rdata SHALL equal ram_dout. For writes this is the pre-write content (read-first).
REQ-031 a_rsp_valid and b_rsp_valid SHALL never be high in the same cycle.
REQ-032 Responses carry no back-pressure. Throughput is one request per cycle, sustained.
REQ-033 Write to addr X accepted at edge N, then a read of X accepted at edge N+1: the read response SHALL return the newly written data. No stall and no hazard logic are required.
REQ-034 x_grant_cnt SHALL increment by 1 on each handshake of that port and saturate at 2^CNT_WIDTH-1.
REQ-035 cnt_clr SHALL zero both counters. If cnt_clr coincides with a handshake, the cleared value 0 SHALL win.

Reset
REQ-036 While rst_n=0 at a rising edge, the following SHALL be set:
- ram_we=0, ram_addr=0, ram_din=0
- pipeline tags invalid
- pointer = port A
- both counters = 0
REQ-037 Requests in flight at reset SHALL be discarded: no rsp_valid SHALL occur in any cycle after a reset edge for those requests.
REQ-038 x_req_ready SHALL be 0 while rst_n=0.

Verification
REQ-039 A writes 0x5A to addr 0x10, then A reads 0x10 back to back -> two A rsp pulses; the second carries rsp_rdata=0x5A; the first carries the prior content.
REQ-040 A and B both valid continuously for 6 cycles after reset -> grants A,B,A,B,A,B; a_grant_cnt=3, b_grant_cnt=3; responses alternate A,B two cycles later.
REQ-041 Only B valid for 3 cycles, then both valid -> B,B,B granted, then A (pointer at A), then B.
REQ-042 Read of addr 0x20 accepted, rst_n low on the next edge -> no rsp_valid on either port; ram_we=0; pointer=A.
REQ-043 Force a_grant_cnt to 0xFFFF, grant A again -> holds 0xFFFF. cnt_clr together with a grant -> 0x0000.
REQ-044 Random mixed read/write traffic from both ports against a reference memory model -> every response arrives on the correct port after exactly 2 cycles, with matching data; ram_we never asserted without an accepted write.
